// File: rtl/vitdec_pkg.sv
// Shared constants and trellis helpers for the rate-1/2, K=3 (7,5) Viterbi decoder.
package vitdec_pkg;
  localparam int NUM_STATES = 4;
  localparam int K = 3;
  localparam logic [2:0] G_HI = 3'b111;
  localparam logic [2:0] G_LO = 3'b101;
  localparam int PM_INIT = 4;

  // state = {m1,m0}; the tap vector is {d,m1,m0}
  function automatic logic [1:0] exp_sym(input logic [1:0] state, input logic d);
    logic [2:0] w_taps;
    w_taps  = {d, state};
    exp_sym = {^(w_taps & G_HI), ^(w_taps & G_LO)};
  endfunction

  function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] w_x;
    w_x      = a ^ b;
    hamming2 = {1'b0, w_x[1]} + {1'b0, w_x[0]};
  endfunction
endpackage

// File: rtl/vitdec_acs.sv
// One add-compare-select unit plus register-exchange survivor update for a single next state.
module vitdec_acs
  import vitdec_pkg::*;
#(
  parameter int TB_DEPTH = 15,
  parameter int PM_W     = 5
) (
  input  logic                i_d,
  input  logic [PM_W-1:0]     i_pm0,
  input  logic [PM_W-1:0]     i_pm1,
  input  logic [1:0]          i_bm0,
  input  logic [1:0]          i_bm1,
  input  logic [TB_DEPTH-2:0] i_sv0,
  input  logic [TB_DEPTH-2:0] i_sv1,
  output logic [PM_W-1:0]     o_pm,
  output logic [TB_DEPTH-1:0] o_sv
);
  logic [PM_W-1:0]     w_cand0;
  logic [PM_W-1:0]     w_cand1;
  logic                w_sel;
  logic [TB_DEPTH-2:0] w_sv_sel;

  assign w_cand0 = i_pm0 + PM_W'(i_bm0);
  assign w_cand1 = i_pm1 + PM_W'(i_bm1);
  // strict compare so a tie keeps the m0=0 predecessor
  assign w_sel    = (w_cand1 < w_cand0);
  assign o_pm     = w_sel ? w_cand1 : w_cand0;
  assign w_sv_sel = w_sel ? i_sv1 : i_sv0;
  assign o_sv     = {w_sv_sel, i_d};
endmodule

// File: rtl/vitdec_rx.sv
// Hard-decision Viterbi decoder: BM generation, four ACS units, normalisation,
// best-state pick and the decoded-bit output registers.
module vitdec_rx
  import vitdec_pkg::*;
#(
  parameter int TB_DEPTH = 15,
  parameter int PM_W     = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [1:0] sym_in,
  output logic       dec_valid,
  output logic       dec_out
);
  // Handshake: in_valid qualifies sym_in and every valid cycle is consumed (no ready);
  // dec_valid is a one-cycle strobe that the sink must take whenever it is high.
  localparam int CNT_W = $clog2(TB_DEPTH);
  localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(TB_DEPTH - 1);

  logic [PM_W-1:0]     r_pm [NUM_STATES];
  // The oldest survivor bit is only ever needed for the output, which reads it
  // from the freshly exchanged survivors, so stored survivors omit it.
  logic [TB_DEPTH-2:0] r_sv [NUM_STATES];
  logic [CNT_W-1:0]    r_fill;
  logic                r_dec_valid;
  logic                r_dec_out;

  logic [PM_W-1:0]     w_pm_new [NUM_STATES];
  logic [TB_DEPTH-1:0] w_sv_new [NUM_STATES];
  logic [PM_W-1:0]     w_pm_min;
  logic [1:0]          w_best;

  for (genvar n = 0; n < NUM_STATES; n++) begin : g_acs
    localparam int   P0 = (n % 2) * 2;
    localparam int   P1 = P0 + 1;
    localparam logic D  = 1'((n / 2) % 2);
    logic [1:0] w_bm0;
    logic [1:0] w_bm1;

    assign w_bm0 = hamming2(sym_in, exp_sym(2'(P0), D));
    assign w_bm1 = hamming2(sym_in, exp_sym(2'(P1), D));

    vitdec_acs #(.TB_DEPTH(TB_DEPTH), .PM_W(PM_W)) u_acs (
      .i_d   (D),
      .i_pm0 (r_pm[P0]),
      .i_pm1 (r_pm[P1]),
      .i_bm0 (w_bm0),
      .i_bm1 (w_bm1),
      .i_sv0 (r_sv[P0]),
      .i_sv1 (r_sv[P1]),
      .o_pm  (w_pm_new[n]),
      .o_sv  (w_sv_new[n])
    );
  end

  always_comb begin
    w_pm_min = w_pm_new[0];
    w_best   = 2'd0;
    for (int i = 1; i < NUM_STATES; i++) begin
      if (w_pm_new[i] < w_pm_min) begin
        w_pm_min = w_pm_new[i];
        w_best   = 2'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_STATES; i++) begin
        r_pm[i] <= (i == 0) ? '0 : PM_W'(PM_INIT);
        r_sv[i] <= '0;
      end
      r_fill      <= '0;
      r_dec_valid <= 1'b0;
      r_dec_out   <= 1'b0;
    end else if (in_valid) begin
      for (int i = 0; i < NUM_STATES; i++) begin
        r_pm[i] <= w_pm_new[i] - w_pm_min;
        r_sv[i] <= w_sv_new[i][TB_DEPTH-2:0];
      end
      if (r_fill != FILL_MAX) r_fill <= r_fill + CNT_W'(1);
      r_dec_valid <= (r_fill == FILL_MAX);
      r_dec_out   <= w_sv_new[w_best][TB_DEPTH-1];
    end else begin
      r_dec_valid <= 1'b0;
    end
  end

  assign dec_valid = r_dec_valid;
  assign dec_out   = r_dec_out;
endmodule
